// File: rtl/isa_pkg.sv
// Shared fetch-side definitions: instruction/address widths, boot PC,
// the prefetch entry layout and the fetch FSM states.
package isa_pkg;

    localparam int INSTR_W = 19;
    localparam int ADDR_W  = 10;
    localparam int BOOT_PC = 0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fq_fifo.sv
// Circular prefetch buffer with simultaneous push/pop and a synchronous flush
// that overrides both. Storage is not reset; only pointers and count are.
module fq_fifo
    import isa_pkg::*;
#(
    parameter int W     = INSTR_W + ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop_ok;
    logic          push_ok;

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues credit-limited memory reads, buffers the
// returned words with their PCs and hands them to the decoder by valid/ready.
module fetch_queue
    import isa_pkg::*;
#(
    parameter int IW       = INSTR_W,
    parameter int AW       = ADDR_W,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = BOOT_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic [IW-1:0]            imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [IW-1:0]            instr_out,
    output logic [AW-1:0]            instr_pc,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + IW;
    localparam logic [AW-1:0] PC0 = AW'(RESET_PC);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [AW-1:0]   fetch_pc;
    logic [AW-1:0]   pc_pipe;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            pop;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head_data;
    logic [CW-1:0]   count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    // Credit check counts the word still in flight so the buffer can never overflow.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN:  issue = fetch_en && !redirect &&
                          (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= PC0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) fetch_pc <= fetch_pc + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) pc_pipe <= fetch_pc;
    end

    // A response landing in a redirect cycle belongs to the old path and is dropped.
    assign push      = inflight && !redirect;
    assign push_data = {pc_pipe, imem_rdata};
    assign pop       = instr_valid && instr_ready;

    fq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head_data),
        .count     (count)
    );

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? head_data[IW-1:0]  : '0;
    assign instr_pc    = instr_valid ? head_data[EW-1:IW] : '0;
    assign q_count     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory returns addr+0x100, a scoreboard of expected
// {pc, instr} entries is checked against every accepted transfer.
module tb_fetch_queue;
    import isa_pkg::*;

    localparam int IW    = 19;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [2:0]    q_count;

    int errors = 0;
    int checks = 0;
    fq_entry_t exp_q[$];

    fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a) + 19'h100;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic push_exp(input logic [AW-1:0] start, input int n);
        fq_entry_t e;
        logic [AW-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            e.pc    = a;
            e.instr = mem_word(a);
            exp_q.push_back(e);
            a = a + AW'(1);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected entry.
    always @(negedge clk) begin
        fq_entry_t e;
        if (!rst) begin
            checks++;
            if (q_count > 3'(DEPTH)) begin
                errors++;
                $display("FAIL q_count_bound got %0d max %0d", q_count, DEPTH);
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got pc=%h instr=%h want none", instr_pc, instr_out);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e.pc || instr_out !== e.instr) begin
                        errors++;
                        $display("FAIL sb_data got pc=%h instr=%h want pc=%h instr=%h",
                                 instr_pc, instr_out, e.pc, e.instr);
                    end
                end
            end
        end
    end

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        instr_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b req=%b cnt=%0d want 0 0 0", instr_valid, imem_req, q_count);
        end
        checks++;
        if (imem_addr !== 10'h000 || instr_out !== 19'h0 || instr_pc !== 10'h000) begin
            errors++;
            $display("FAIL reset_data got addr=%h out=%h pc=%h want 0 0 0", imem_addr, instr_out, instr_pc);
        end
    endtask

    task automatic test_startup();
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        push_exp(10'h000, 12);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_idle got req=%b valid=%b want 0 0", imem_req, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h valid=%b want 1 000 0", imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 10'h001) begin
            errors++;
            $display("FAIL second_req got valid=%b addr=%h want 0 001", instr_valid, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid got %b want 1", instr_valid);
        end
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_gap cycle %0d got valid=%b want 1", i, instr_valid);
            end
        end
        @(posedge clk); #1;
        instr_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL startup_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        repeat (10) @(negedge clk);
        checks++;
        if (q_count !== 3'd4 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got cnt=%0d req=%b want 4 0", q_count, imem_req);
        end
        checks++;
        if (instr_pc !== 10'h00c || instr_out !== 19'h0010c) begin
            errors++;
            $display("FAIL bp_head got pc=%h instr=%h want 00c 0010c", instr_pc, instr_out);
        end
        push_exp(10'h00c, 12);
        drain(60, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        bit ok;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 10'h100;
        @(posedge clk); #1;
        redirect = 1'b0;
        exp_q.delete();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_count == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_fill got cnt=%0d want 3", q_count);
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rd_credit got req=%b want 0", imem_req);
        end
        redirect = 1'b1; redirect_pc = 10'h200;
        push_exp(10'h200, 8);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL rd_flush got valid=%b cnt=%0d want 0 0", instr_valid, q_count);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h200) begin
            errors++;
            $display("FAIL rd_newreq got req=%b addr=%h want 1 200", imem_req, imem_addr);
        end
        drain(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 10'h3fe;
        exp_q.delete();
        push_exp(10'h3fe, 4);
        @(posedge clk); #1;
        redirect = 1'b0;
        drain(30, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL wrap_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 10'h050;
        @(posedge clk); #1;
        redirect_pc = 10'h080;
        exp_q.delete();
        push_exp(10'h080, 4);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h080) begin
            errors++;
            $display("FAIL b2b_req got req=%b addr=%h want 1 080", imem_req, imem_addr);
        end
        drain(30, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_fetch_en();
        bit ok;
        @(posedge clk); #1;
        fetch_en = 1'b0;
        redirect = 1'b1; redirect_pc = 10'h020;
        @(posedge clk); #1;
        redirect = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL fe_hold got req=%b cnt=%0d want 0 0", imem_req, q_count);
        end
        @(posedge clk); #1;
        fetch_en = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h020) begin
            errors++;
            $display("FAIL fe_req got req=%b addr=%h want 1 020", imem_req, imem_addr);
        end
        @(posedge clk); #1;
        fetch_en = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL fe_stop got req=%b cnt=%0d want 0 0", imem_req, q_count);
        end
        @(negedge clk);
        checks++;
        if (q_count !== 3'd1 || instr_valid !== 1'b1 || instr_pc !== 10'h020) begin
            errors++;
            $display("FAIL fe_land got cnt=%0d valid=%b pc=%h want 1 1 020", q_count, instr_valid, instr_pc);
        end
        push_exp(10'h020, 1);
        drain(10, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL fe_drain got left=%0d want 0", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || q_count !== 3'd0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fe_empty got valid=%b cnt=%0d req=%b want 0 0 0", instr_valid, q_count, imem_req);
        end
        fetch_en = 1'b1;
    endtask

    task automatic test_async_reset();
        bit ok;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 10'h010;
        @(posedge clk); #1;
        redirect = 1'b0;
        exp_q.delete();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_count == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL ar_fill got cnt=%0d want 2", q_count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || q_count !== 3'd0 || imem_addr !== 10'h000) begin
            errors++;
            $display("FAIL ar_async got valid=%b req=%b cnt=%0d addr=%h want 0 0 0 000",
                     instr_valid, imem_req, q_count, imem_addr);
        end
        exp_q.delete();
        push_exp(10'h000, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL ar_boot got req=%b want 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            errors++;
            $display("FAIL ar_restart got req=%b addr=%h want 1 000", imem_req, imem_addr);
        end
        drain(30, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL ar_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_fetch_en();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
